// File: rtl/key_tone_player.sv
// key_tone_player
//   Receives the 9-bit key pad bus and decodes one key into a note and an
//   octave. It then plays that note as a 50% duty square wave on the speaker
//   pin and reports the decoded key on the status LEDs.
//
//   Processing chain:
//     key_input -> 2-flop synchroniser -> debouncer (accepted key)
//               -> note decode -> tone counter -> audio_out
//   All timing comes from an internal tick. The tick fires once every
//   CLK_DIV system clocks, which gives 1 MHz from a 100 MHz clock.
//
// Parameters
//   CLK_DIV         system clocks per tick
//   DEBOUNCE_TICKS  ticks the synchronised key must stay stable before it
//                   is accepted
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous, active-low reset
//   key_input    {octave[1:0], note_onehot[6:0]}; bit0 = C ... bit6 = B.
//                This bus is asynchronous to clk.
//   audio_out    square-wave tone, 50% duty; low while silent
//   led          {octave[1:0], note_idx[2:0]}; note_idx 1..7 = C..B,
//                0 = silent
//   tone_active  high while a valid note is being played
module key_tone_player #(
  parameter int CLK_DIV        = 100,
  parameter int DEBOUNCE_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] key_input,
  output logic       audio_out,
  output logic [4:0] led,
  output logic       tone_active
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_TICKS);

  // ---------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;

  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Two-flop synchroniser on every key bit
  // ---------------------------------------------------------------------
  logic [8:0] sync1_reg;
  logic [8:0] key_s_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      key_s_reg <= '0;
    end else begin
      sync1_reg <= key_input;
      key_s_reg <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer
  //   cand follows key_s on any clock, and every difference restarts the
  //   stability count. The candidate is promoted to acc_key only once it
  //   has been stable for DEBOUNCE_TICKS ticks.
  // ---------------------------------------------------------------------
  logic [8:0]        cand_reg;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic [8:0]        acc_key_reg;
  logic              key_change;

  // A key change happens only when the stored value actually differs.
  // Accepting the same value again therefore does not disturb the tone.
  assign key_change = (stab_cnt_reg == STAB_MAX) && (cand_reg != acc_key_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg     <= '0;
      stab_cnt_reg <= '0;
      acc_key_reg  <= '0;
    end else begin
      if (key_s_reg != cand_reg) begin
        cand_reg     <= key_s_reg;
        stab_cnt_reg <= '0;
      end else if (tick && (stab_cnt_reg != STAB_MAX)) begin
        stab_cnt_reg <= stab_cnt_reg + 1'b1;
      end

      if (key_change) begin
        acc_key_reg <= cand_reg;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Decode of the accepted key
  // ---------------------------------------------------------------------
  logic [2:0]  ones_cnt;
  logic [2:0]  note_idx;
  logic        note_valid;
  logic [10:0] half_base;
  logic [10:0] half_period;

  always_comb begin
    ones_cnt = 3'd0;
    note_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (acc_key_reg[i]) begin
        ones_cnt = ones_cnt + 3'd1;
        note_idx = 3'(i + 1);
      end
    end
    note_valid = (ones_cnt == 3'd1);
  end

  // Octave-0 half periods in ticks. Each higher octave halves the period.
  always_comb begin
    case (note_idx)
      3'd1:    half_base = 11'd1911;  // C
      3'd2:    half_base = 11'd1703;  // D
      3'd3:    half_base = 11'd1517;  // E
      3'd4:    half_base = 11'd1432;  // F
      3'd5:    half_base = 11'd1276;  // G
      3'd6:    half_base = 11'd1136;  // A
      3'd7:    half_base = 11'd1012;  // B
      default: half_base = 11'd0;
    endcase
    half_period = half_base >> acc_key_reg[8:7];
  end

  // ---------------------------------------------------------------------
  // Tone generator
  //   A key change clears the phase on the same edge that acc_key updates.
  //   The new note then always starts from a low level.
  // ---------------------------------------------------------------------
  logic [10:0] half_cnt_reg;
  logic        audio_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_reg <= '0;
      audio_reg    <= 1'b0;
    end else if (key_change || !note_valid) begin
      half_cnt_reg <= '0;
      audio_reg    <= 1'b0;
    end else if (tick) begin
      if (half_cnt_reg == half_period - 11'd1) begin
        half_cnt_reg <= '0;
        audio_reg    <= ~audio_reg;
      end else begin
        half_cnt_reg <= half_cnt_reg + 11'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered status outputs
  // ---------------------------------------------------------------------
  logic [4:0] led_reg;
  logic       tone_active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg         <= '0;
      tone_active_reg <= 1'b0;
    end else begin
      led_reg         <= note_valid ? {acc_key_reg[8:7], note_idx} : 5'b00000;
      tone_active_reg <= note_valid;
    end
  end

  assign audio_out   = audio_reg;
  assign led         = led_reg;
  assign tone_active = tone_active_reg;

endmodule
